// File: rtl/ascon_out_framer.sv
// ascon_out_framer: consumer side of the Ascon core output interface.
// Collects bdo words into a segment buffer and emits a framed 32-bit stream:
// one header word {op[3:0], flags[3:0], len[23:0]} followed by the data words.
// Tag verification results are emitted as a single word {4'hF, 3'b000, auth, 24'h0}.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   bdo, bdo_valid, bdo_ready    output data word from the core (handshake)
//   bdo_type, bdo_eot            word type and end-of-segment marker
//   auth, auth_valid, auth_ready tag verification result (handshake)
//   out_data, out_valid, out_ready framed output stream to the sink
module ascon_out_framer #(
  parameter int unsigned CCW   = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CCW-1:0] bdo,
  input  logic           bdo_valid,
  output logic           bdo_ready,
  input  logic [3:0]     bdo_type,
  input  logic           bdo_eot,
  input  logic           auth,
  input  logic           auth_valid,
  output logic           auth_ready,
  output logic [31:0]    out_data,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LastIdx = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic [1:0] {StCollect, StAuth, StHdr, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [3:0]      type_q, type_d;
  logic            eot_q, eot_d;    // header flags[0]: closed by eot
  logic            seg_q, seg_d;    // a closed segment awaits its header
  logic            auth_q, auth_d;
  logic            run_q;           // holds input readies low for one cycle after reset
  // A word of a different type closes the current segment; it is parked here
  // so it is never dropped, then seeds the next segment.
  logic            pend_q, pend_d;
  logic [CCW-1:0]  pend_data_q, pend_data_d;
  logic [3:0]      pend_type_q, pend_type_d;
  logic            pend_eot_q, pend_eot_d;

  logic [CCW-1:0]  mem [DEPTH];
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [CCW-1:0]  wr_data;
  logic            closed;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    type_d      = type_q;
    eot_d       = eot_q;
    seg_d       = seg_q;
    auth_d      = auth_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pend_type_d = pend_type_q;
    pend_eot_d  = pend_eot_q;
    bdo_ready   = 1'b0;
    auth_ready  = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    wr_en       = 1'b0;
    wr_addr     = cnt_q[AW-1:0];
    wr_data     = bdo;
    closed      = 1'b0;

    unique case (state_q)
      StCollect: begin
        bdo_ready  = run_q;
        auth_ready = run_q && (cnt_q == '0);
        if (auth_valid && auth_ready) begin
          auth_d  = auth;
          state_d = StAuth;
        end
        if (bdo_valid && bdo_ready) begin
          if ((cnt_q != '0) && (bdo_type != type_q)) begin
            pend_d      = 1'b1;
            pend_data_d = bdo;
            pend_type_d = bdo_type;
            pend_eot_d  = bdo_eot;
            eot_d       = 1'b0;
            closed      = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CntOne;
            if (cnt_q == '0) type_d = bdo_type;
            if (bdo_eot) begin
              eot_d  = 1'b1;
              closed = 1'b1;
            end else if (cnt_q == LastIdx) begin
              eot_d  = 1'b0;
              closed = 1'b1;
            end
          end
        end
        // An auth accepted together with a closing word is emitted first.
        if (closed) begin
          seg_d = 1'b1;
          if (state_d != StAuth) state_d = StHdr;
        end
      end
      StAuth: begin
        out_valid = 1'b1;
        out_data  = {4'hF, 3'b000, auth_q, 24'h000000};
        if (out_ready) state_d = seg_q ? StHdr : StCollect;
      end
      StHdr: begin
        out_valid = 1'b1;
        out_data  = {type_q, 3'b000, eot_q, 24'({cnt_q, 2'b00})};
        if (out_ready) begin
          rd_d    = '0;
          seg_d   = 1'b0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        out_valid = 1'b1;
        out_data  = mem[rd_q];
        if (out_ready) begin
          if ({1'b0, rd_q} == cnt_q - CntOne) begin
            cnt_d   = '0;
            state_d = StCollect;
            if (pend_q) begin
              pend_d  = 1'b0;
              wr_en   = 1'b1;
              wr_addr = '0;
              wr_data = pend_data_q;
              cnt_d   = CntOne;
              type_d  = pend_type_q;
              if (pend_eot_q) begin
                eot_d   = 1'b1;
                seg_d   = 1'b1;
                state_d = StHdr;
              end
            end
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      cnt_q       <= '0;
      rd_q        <= '0;
      type_q      <= '0;
      eot_q       <= 1'b0;
      seg_q       <= 1'b0;
      auth_q      <= 1'b0;
      run_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_type_q <= '0;
      pend_eot_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      type_q      <= type_d;
      eot_q       <= eot_d;
      seg_q       <= seg_d;
      auth_q      <= auth_d;
      run_q       <= 1'b1;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_type_q <= pend_type_d;
      pend_eot_q  <= pend_eot_d;
    end
  end

  // Buffer contents need no reset; cnt_q defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_ascon_out_framer.sv
module tb_ascon_out_framer;

  localparam logic [3:0] D_PTCT = 4'h3;
  localparam logic [3:0] D_TAG  = 4'h4;
  localparam logic [3:0] D_HASH = 4'h5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bdo = '0;
  logic        bdo_valid = 1'b0;
  logic        bdo_ready;
  logic [3:0]  bdo_type = '0;
  logic        bdo_eot = 1'b0;
  logic        auth = 1'b0;
  logic        auth_valid = 1'b0;
  logic        auth_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  logic toggle_mode = 1'b0;
  logic [31:0] exp_q[$];

  ascon_out_framer #(.CCW(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
    .bdo_type(bdo_type), .bdo_eot(bdo_eot),
    .auth(auth), .auth_valid(auth_valid), .auth_ready(auth_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (toggle_mode) out_ready = ~out_ready;
  end

  // Monitor: whatever is valid & ready at the negedge transfers on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (bdo_ready || auth_ready) begin
        errors++;
        $display("FAIL in_ready_during_output: bdo_ready=%0b auth_ready=%0b required 0/0",
                 bdo_ready, auth_ready);
      end
      if (out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %08h, expected no output", out_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_word: got %08h required %08h", out_data, e);
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] t, input logic e);
    int n;
    n = 0;
    bdo = d; bdo_type = t; bdo_eot = e; bdo_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bdo_ready && n < 500);
    if (!bdo_ready) begin
      errors++; checks++;
      $display("FAIL bdo_accept_timeout: bdo_ready=0 required 1");
    end
    @(posedge clk);
    #1;
    bdo_valid = 1'b0; bdo_eot = 1'b0;
  endtask

  task automatic send_auth(input logic a);
    int n;
    n = 0;
    auth = a; auth_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!auth_ready && n < 500);
    if (!auth_ready) begin
      errors++; checks++;
      $display("FAIL auth_accept_timeout: auth_ready=0 required 1");
    end
    @(posedge clk);
    #1;
    auth_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d words pending, required 0", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: out_valid=%0b required 0", name, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    // Reset state
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || bdo_ready !== 1'b0 || auth_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%0b out_data=%08h bdo_ready=%0b auth_ready=%0b required 0",
               out_valid, out_data, bdo_ready, auth_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: basic eot-closed segment
    exp_q.push_back(32'h31000010);
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'h11111111 * i);
    for (int i = 1; i <= 4; i++) send_word(32'h11111111 * i, D_PTCT, i == 4);
    wait_drain("t1");

    // 2: out_ready toggling
    toggle_mode = 1'b1;
    exp_q.push_back(32'h41000010);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0A0A0A0 + i);
    for (int i = 0; i < 4; i++) send_word(32'hA0A0A0A0 + i, D_TAG, i == 3);
    wait_drain("t2");
    toggle_mode = 1'b0;
    out_ready = 1'b1;

    // 3: 10-word segment split at DEPTH
    exp_q.push_back(32'h30000020);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hC0000000 + i);
    exp_q.push_back(32'h31000008);
    for (int i = 8; i < 10; i++) exp_q.push_back(32'hC0000000 + i);
    for (int i = 0; i < 10; i++) send_word(32'hC0000000 + i, D_PTCT, i == 9);
    wait_drain("t3");

    // 4: auth results with empty buffer
    exp_q.push_back(32'hF1000000);
    send_auth(1'b1);
    wait_drain("t4a");
    exp_q.push_back(32'hF0000000);
    send_auth(1'b0);
    wait_drain("t4b");

    // 5: type break closes the segment as split
    exp_q.push_back(32'h30000008);
    exp_q.push_back(32'h55550001);
    exp_q.push_back(32'h55550002);
    exp_q.push_back(32'h41000004);
    exp_q.push_back(32'h7A6B0003);
    send_word(32'h55550001, D_PTCT, 1'b0);
    send_word(32'h55550002, D_PTCT, 1'b0);
    send_word(32'h7A6B0003, D_TAG, 1'b1);
    wait_drain("t5");

    // 6: reset mid-drain discards the rest of the segment
    out_ready = 1'b0;
    exp_q.push_back(32'h31000010);
    exp_q.push_back(32'hD0000000);
    for (int i = 0; i < 4; i++) send_word(32'hD0000000 + i, D_PTCT, i == 3);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t6_after_reset: out_valid=%0b required 0", out_valid);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL t6_pre_reset_words: %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    w = 32'hBEEF0042;
    exp_q.push_back(32'h51000004);
    exp_q.push_back(w);
    send_word(w, D_HASH, 1'b1);
    wait_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
